// File: rtl/cv32e40px_fpu_op_tracker.sv
// In-order tracker of FPU ops in flight: issue queue, writeback tags, RAW hazard flags.
// Optional per-group issue counters enabled by CV32E40PX_FPU_TRACKER_PERF_EN.
package cv32e40px_fpu_pkg;
   localparam int OP_BITS        = 4;
   localparam int FP_FORMAT_BITS = 3;

   typedef enum logic [OP_BITS-1:0] {
      FMADD, FNMSUB, ADD, MUL,
      DIV, SQRT,
      SGNJ, MINMAX, CMP, CLASSIFY,
      F2F, F2I, I2F, CPKAB, CPKCD
   } operation_e;

   typedef enum logic [FP_FORMAT_BITS-1:0] {
      FP32, FP64, FP16, FP8, FP16ALT
   } fp_format_e;
endpackage

module cv32e40px_fpu_op_tracker
   import cv32e40px_fpu_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int REG_ADDR_W = 6,
   parameter int NUM_CHECK  = 3,
   localparam int PTR_W     = $clog2(DEPTH),
   localparam int CNT_W     = PTR_W + 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          flush_i,
   input  logic                          issue_valid_i,
   output logic                          issue_ready_o,
   input  logic [OP_BITS-1:0]            issue_op_i,
   input  logic [FP_FORMAT_BITS-1:0]     issue_fmt_i,
   input  logic [REG_ADDR_W-1:0]         issue_rd_i,
   input  logic                          fpu_rvalid_i,
   output logic                          wb_valid_o,
   output logic [OP_BITS-1:0]            wb_op_o,
   output logic [FP_FORMAT_BITS-1:0]     wb_fmt_o,
   output logic [REG_ADDR_W-1:0]         wb_rd_o,
   input  logic [NUM_CHECK*REG_ADDR_W-1:0] check_addr_i,
   output logic [NUM_CHECK-1:0]          hazard_o,
   output logic [CNT_W-1:0]              count_o,
   output logic                          empty_o,
   output logic                          full_o,
   output logic                          err_o,
   output logic [4*32-1:0]               perf_cnt_o
);

   logic [OP_BITS-1:0]        op_q  [DEPTH];
   logic [FP_FORMAT_BITS-1:0] fmt_q [DEPTH];
   logic [REG_ADDR_W-1:0]     rd_q  [DEPTH];
   logic [DEPTH-1:0]          vld_q;

   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             err_q;
   logic             accept;
   logic             retire;

   assign empty_o       = (count_q == '0);
   assign full_o        = (count_q == CNT_W'(DEPTH));
   assign count_o       = count_q;
   assign err_o         = err_q;
   assign issue_ready_o = !full_o;

   // Flush wins over both issue and completion in the same cycle.
   assign accept     = issue_valid_i & issue_ready_o & !flush_i;
   assign retire     = fpu_rvalid_i & !empty_o & !flush_i;
   assign wb_valid_o = retire;

   always_comb begin
      count_d = count_q;
      unique case ({accept, retire})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            op_q[i]  <= '0;
            fmt_q[i] <= '0;
            rd_q[i]  <= '0;
         end
         vld_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         vld_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         // Pointers differ whenever both fire, so the two vld updates never collide.
         if (retire) begin
            vld_q[rd_ptr_q] <= 1'b0;
            rd_ptr_q        <= rd_ptr_q + PTR_W'(1);
         end
         if (accept) begin
            op_q[wr_ptr_q]  <= issue_op_i;
            fmt_q[wr_ptr_q] <= issue_fmt_i;
            rd_q[wr_ptr_q]  <= issue_rd_i;
            vld_q[wr_ptr_q] <= 1'b1;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (fpu_rvalid_i & empty_o & !flush_i) begin
         err_q <= 1'b1;
      end
   end

   always_comb begin
      wb_op_o  = '0;
      wb_fmt_o = '0;
      wb_rd_o  = '0;
      if (retire) begin
         wb_op_o  = op_q[rd_ptr_q];
         wb_fmt_o = fmt_q[rd_ptr_q];
         wb_rd_o  = rd_q[rd_ptr_q];
      end
   end

   // Head stays visible to the comparators even while it retires.
   always_comb begin
      hazard_o = '0;
      for (int c = 0; c < NUM_CHECK; c++) begin
         for (int e = 0; e < DEPTH; e++) begin
            if (vld_q[e] &&
                rd_q[e] == check_addr_i[c*REG_ADDR_W +: REG_ADDR_W]) begin
               hazard_o[c] = 1'b1;
            end
         end
      end
   end

`ifdef CV32E40PX_FPU_TRACKER_PERF_EN
   logic [3:0]  grp_hit;
   logic [31:0] perf_q [4];

   always_comb begin
      grp_hit = '0;
      unique case (1'b1)
         (issue_op_i <= OP_BITS'(MUL)):
            grp_hit[0] = 1'b1;
         (issue_op_i >= OP_BITS'(DIV) &&
          issue_op_i <= OP_BITS'(SQRT)):
            grp_hit[1] = 1'b1;
         (issue_op_i >= OP_BITS'(SGNJ) &&
          issue_op_i <= OP_BITS'(CLASSIFY)):
            grp_hit[2] = 1'b1;
         (issue_op_i >= OP_BITS'(F2F) &&
          issue_op_i <= OP_BITS'(CPKCD)):
            grp_hit[3] = 1'b1;
         default: grp_hit = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int g = 0; g < 4; g++) perf_q[g] <= '0;
      end else begin
         for (int g = 0; g < 4; g++) begin
            if (accept && grp_hit[g]) perf_q[g] <= perf_q[g] + 32'd1;
         end
      end
   end

   assign perf_cnt_o = {perf_q[3], perf_q[2], perf_q[1], perf_q[0]};
`else
   assign perf_cnt_o = '0;
`endif

endmodule
